// File: rtl/traffic_light_fsm.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_fsm
// Purpose  : Light sequencer for a main/side road junction. It takes the
//            expiry flags from the interval timer, restarts that timer on
//            every state change, and drives the one-hot lamp outputs. The
//            main road has priority. The side road is served only when a
//            car request is latched. If the timer goes silent, a watchdog
//            forces a blinking-yellow FAULT state that only reset can leave.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_fsm #(
    parameter int BLANK_CYC = 1,
    parameter int WDOG_CYC  = 1024,
    parameter int WDOG_W    = 11,
    parameter int BLINK_CYC = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tMG,
    input  logic       tMY,
    input  logic       tSG,
    input  logic       tSY,
    input  logic       car_side,
    output logic       tstart,
    output logic [2:0] main_lt,
    output logic [2:0] side_lt,
    output logic       fault,
    output logic [2:0] state
);

    localparam logic [2:0] c_ST_MG    = 3'd0;
    localparam logic [2:0] c_ST_MY    = 3'd1;
    localparam logic [2:0] c_ST_SG    = 3'd2;
    localparam logic [2:0] c_ST_SY    = 3'd3;
    localparam logic [2:0] c_ST_FAULT = 3'd4;

    // Lamp encodings {R,Y,G}
    localparam logic [2:0] c_LT_RED = 3'b100;
    localparam logic [2:0] c_LT_YEL = 3'b010;
    localparam logic [2:0] c_LT_GRN = 3'b001;
    localparam logic [2:0] c_LT_OFF = 3'b000;

    localparam int c_BLANK_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam int c_BLINK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic                 r_tstart;
    logic [c_BLANK_W-1:0] r_blank;
    logic [WDOG_W-1:0]    r_wdog;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blink_ph;
    logic                 r_side_req;

    logic                 w_blank;
    logic                 w_qexp;
    logic                 w_req;
    logic                 w_wdog_trip;
    logic                 w_enter;
    logic                 w_enter_run;

    // Expiry levels may still be high from the previous interval, so they are
    // ignored during the restart cycle and the blanking window after it.
    assign w_blank     = r_tstart | (r_blank != '0);
    assign w_req       = r_side_req | car_side;
    assign w_wdog_trip = (r_wdog == WDOG_W'(WDOG_CYC - 1)) && !w_qexp;
    assign w_enter     = (w_next_state != r_state);
    // Entering FAULT does not restart the timer.
    assign w_enter_run = w_enter && (w_next_state != c_ST_FAULT);

    // Select only the expiry flag that belongs to the current state.
    always_comb begin
        w_qexp = 1'b0;
        case (r_state)
            c_ST_MG: w_qexp = tMG;
            c_ST_MY: w_qexp = tMY;
            c_ST_SG: w_qexp = tSG;
            c_ST_SY: w_qexp = tSY;
            default: w_qexp = 1'b0;
        endcase
        if (w_blank) begin
            w_qexp = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_MG;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. MG holds green indefinitely until a side request is present.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_MG: begin
                if (w_qexp && w_req) begin
                    w_next_state = c_ST_MY;
                end else if (w_wdog_trip) begin
                    w_next_state = c_ST_FAULT;
                end
            end
            c_ST_MY: begin
                if (w_qexp) begin
                    w_next_state = c_ST_SG;
                end else if (w_wdog_trip) begin
                    w_next_state = c_ST_FAULT;
                end
            end
            c_ST_SG: begin
                if (w_qexp) begin
                    w_next_state = c_ST_SY;
                end else if (w_wdog_trip) begin
                    w_next_state = c_ST_FAULT;
                end
            end
            c_ST_SY: begin
                if (w_qexp) begin
                    w_next_state = c_ST_MG;
                end else if (w_wdog_trip) begin
                    w_next_state = c_ST_FAULT;
                end
            end
            c_ST_FAULT: w_next_state = c_ST_FAULT;
            default:    w_next_state = c_ST_MG;
        endcase
    end

    // Output decode from the state register. FAULT blinks both yellows.
    always_comb begin
        main_lt = c_LT_RED;
        side_lt = c_LT_RED;
        fault   = 1'b0;
        case (r_state)
            c_ST_MG: begin
                main_lt = c_LT_GRN;
                side_lt = c_LT_RED;
            end
            c_ST_MY: begin
                main_lt = c_LT_YEL;
                side_lt = c_LT_RED;
            end
            c_ST_SG: begin
                main_lt = c_LT_RED;
                side_lt = c_LT_GRN;
            end
            c_ST_SY: begin
                main_lt = c_LT_RED;
                side_lt = c_LT_YEL;
            end
            c_ST_FAULT: begin
                fault   = 1'b1;
                main_lt = r_blink_ph ? c_LT_YEL : c_LT_OFF;
                side_lt = r_blink_ph ? c_LT_YEL : c_LT_OFF;
            end
            default: begin
                main_lt = c_LT_RED;
                side_lt = c_LT_RED;
            end
        endcase
    end

    assign tstart = r_tstart;
    assign state  = r_state;

    // Timer restart pulse and the blanking countdown that follows it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tstart <= 1'b1;
            r_blank  <= c_BLANK_W'(BLANK_CYC);
        end else begin
            r_tstart <= w_enter_run;
            if (w_enter_run) begin
                r_blank <= c_BLANK_W'(BLANK_CYC);
            end else if (!r_tstart && (r_blank != '0)) begin
                r_blank <= r_blank - c_BLANK_W'(1);
            end
        end
    end

    // Watchdog: counts cycles spent waiting for the awaited expiry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else if (r_state == c_ST_FAULT) begin
            r_wdog <= r_wdog;
        end else if (w_enter || w_qexp) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
        end
    end

    // Blink timebase. The phase starts lit on FAULT entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b1;
        end else if (r_state != c_ST_FAULT) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b1;
        end else if (r_blink_cnt == c_BLINK_W'(BLINK_CYC - 1)) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= ~r_blink_ph;
        end else begin
            r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
        end
    end

    // Side-road request latch. A new car wins over the clear on SG entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_side_req <= 1'b0;
        end else if (r_state == c_ST_FAULT) begin
            r_side_req <= r_side_req;
        end else if (car_side) begin
            r_side_req <= 1'b1;
        end else if ((w_next_state == c_ST_SG) && (r_state != c_ST_SG)) begin
            r_side_req <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_fsm
// Purpose  : Directed self-checking bench for traffic_light_fsm
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_fsm;

    logic       clk;
    logic       rst_n;
    logic [3:0] flags;     // {tSY,tSG,tMY,tMG}
    logic       car_side;
    logic       tstart;
    logic [2:0] main_lt;
    logic [2:0] side_lt;
    logic       fault;
    logic [2:0] state;

    int n_checks;
    int n_pass;

    traffic_light_fsm #(
        .BLANK_CYC (1),
        .WDOG_CYC  (16),
        .WDOG_W    (5),
        .BLINK_CYC (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tMG      (flags[0]),
        .tMY      (flags[1]),
        .tSG      (flags[2]),
        .tSY      (flags[3]),
        .car_side (car_side),
        .tstart   (tstart),
        .main_lt  (main_lt),
        .side_lt  (side_lt),
        .fault    (fault),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset for two edges and release; returns in the first cycle after release.
    task automatic do_reset();
        rst_n    = 1'b0;
        flags    = 4'b0000;
        car_side = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Reach the first cycle of SG.
    task automatic goto_sg();
        do_reset();
        car_side = 1'b1;
        tick();
        car_side = 1'b0;
        tick();
        flags = 4'b0001;
        tick();
        flags = 4'b0000;
        tick();
        tick();
        flags = 4'b0010;
        tick();
        flags = 4'b0000;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        flags    = 4'b0000;
        car_side = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", state);
        else n_pass++;
        n_checks++;
        if (main_lt !== 3'b001) $display("FAIL reset_main: got %b expected 001", main_lt);
        else n_pass++;
        n_checks++;
        if (side_lt !== 3'b100) $display("FAIL reset_side: got %b expected 100", side_lt);
        else n_pass++;
        n_checks++;
        if (tstart !== 1'b1) $display("FAIL reset_tstart: got %b expected 1", tstart);
        else n_pass++;
        n_checks++;
        if (fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", fault);
        else n_pass++;
        rst_n = 1'b1;
        n_checks++;
        if (tstart !== 1'b1) $display("FAIL release_tstart_hi: got %b expected 1", tstart);
        else n_pass++;
        tick();
        n_checks++;
        if (tstart !== 1'b0) $display("FAIL release_tstart_lo: got %b expected 0", tstart);
        else n_pass++;
        n_checks++;
        if (state !== 3'd0) $display("FAIL release_state: got %0d expected 0", state);
        else n_pass++;
    endtask

    task automatic test_no_car();
        do_reset();
        flags = 4'b0001;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_checks++;
            if (state !== 3'd0 || tstart !== 1'b0 || fault !== 1'b0)
                $display("FAIL no_car_hold cyc %0d: got state=%0d tstart=%b fault=%b expected state=0 tstart=0 fault=0",
                         i, state, tstart, fault);
            else n_pass++;
        end
        flags = 4'b0000;
    endtask

    task automatic test_full_cycle();
        logic [2:0] exp_state [4];
        logic [2:0] exp_main  [4];
        logic [2:0] exp_side  [4];
        logic [3:0] pulse;
        int         extra;
        exp_state[0] = 3'd1; exp_main[0] = 3'b010; exp_side[0] = 3'b100;
        exp_state[1] = 3'd2; exp_main[1] = 3'b100; exp_side[1] = 3'b001;
        exp_state[2] = 3'd3; exp_main[2] = 3'b100; exp_side[2] = 3'b010;
        exp_state[3] = 3'd0; exp_main[3] = 3'b001; exp_side[3] = 3'b100;
        do_reset();
        car_side = 1'b1;
        tick();
        car_side = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            pulse = 4'b0001 << i;
            flags = pulse;
            tick();
            flags = 4'b0000;
            n_checks++;
            if (state !== exp_state[i] || main_lt !== exp_main[i] || side_lt !== exp_side[i])
                $display("FAIL full_entry %0d: got state=%0d main=%b side=%b expected state=%0d main=%b side=%b",
                         i, state, main_lt, side_lt, exp_state[i], exp_main[i], exp_side[i]);
            else n_pass++;
            n_checks++;
            if (tstart !== 1'b1) $display("FAIL full_tstart_entry %0d: got %b expected 1", i, tstart);
            else n_pass++;
            extra = 0;
            for (int j = 0; j < 4; j++) begin
                tick();
                if (tstart === 1'b1) extra++;
            end
            n_checks++;
            if (extra != 0 || state !== exp_state[i])
                $display("FAIL full_dwell %0d: got extra_tstart=%0d state=%0d expected 0 and state=%0d",
                         i, extra, state, exp_state[i]);
            else n_pass++;
        end
        // Side request must have been cleared by SG entry.
        flags = 4'b0001;
        tick();
        flags = 4'b0000;
        n_checks++;
        if (state !== 3'd0 || tstart !== 1'b0)
            $display("FAIL full_req_cleared: got state=%0d tstart=%b expected state=0 tstart=0", state, tstart);
        else n_pass++;
    endtask

    task automatic test_blanking();
        do_reset();
        car_side = 1'b1;
        tick();
        car_side = 1'b0;
        tick();
        flags = 4'b0011;          // tMY already high before MY entry
        tick();
        flags = 4'b0010;
        n_checks++;
        if (state !== 3'd1) $display("FAIL blank_enter_my: got %0d expected 1", state);
        else n_pass++;
        tick();
        n_checks++;
        if (state !== 3'd1) $display("FAIL blank_tstart_cycle: got %0d expected 1", state);
        else n_pass++;
        tick();
        n_checks++;
        if (state !== 3'd1) $display("FAIL blank_window: got %0d expected 1", state);
        else n_pass++;
        tick();
        n_checks++;
        if (state !== 3'd2) $display("FAIL blank_advance: got %0d expected 2", state);
        else n_pass++;
        flags = 4'b0000;
    endtask

    task automatic test_wrong_flag();
        logic [3:0] wrong [3];
        wrong[0] = 4'b0001;
        wrong[1] = 4'b0010;
        wrong[2] = 4'b1000;
        goto_sg();
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            flags = wrong[i];
            tick();
            flags = 4'b0000;
            n_checks++;
            if (state !== 3'd2) $display("FAIL wrong_flag %b: got state %0d expected 2", wrong[i], state);
            else n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        tick();
        tick();
        flags    = 4'b0001;
        car_side = 1'b1;
        tick();
        flags    = 4'b0000;
        car_side = 1'b0;
        n_checks++;
        if (state !== 3'd1 || main_lt !== 3'b010)
            $display("FAIL simul_to_my: got state=%0d main=%b expected state=1 main=010", state, main_lt);
        else n_pass++;
        // Reset mid-operation from MY.
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (state !== 3'd0 || tstart !== 1'b1 || main_lt !== 3'b001)
            $display("FAIL midreset: got state=%0d tstart=%b main=%b expected 0 1 001", state, tstart, main_lt);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_watchdog();
        logic [2:0] exp_lt;
        goto_sg();
        repeat (15) tick();
        n_checks++;
        if (fault !== 1'b0 || state !== 3'd2)
            $display("FAIL wdog_early: got fault=%b state=%0d expected fault=0 state=2", fault, state);
        else n_pass++;
        tick();
        n_checks++;
        if (fault !== 1'b1 || state !== 3'd4 || tstart !== 1'b0)
            $display("FAIL wdog_trip: got fault=%b state=%0d tstart=%b expected 1 4 0", fault, state, tstart);
        else n_pass++;
        for (int k = 0; k < 12; k++) begin
            exp_lt = (((k / 4) % 2) == 0) ? 3'b010 : 3'b000;
            n_checks++;
            if (main_lt !== exp_lt || side_lt !== exp_lt || state !== 3'd4 || tstart !== 1'b0)
                $display("FAIL blink cyc %0d: got main=%b side=%b state=%0d tstart=%b expected lamps=%b state=4 tstart=0",
                         k, main_lt, side_lt, state, tstart, exp_lt);
            else n_pass++;
            flags    = 4'b0001 << (k % 4);
            car_side = k[0];
            tick();
        end
        flags    = 4'b0000;
        car_side = 1'b0;
        rst_n    = 1'b0;
        tick();
        n_checks++;
        if (state !== 3'd0 || fault !== 1'b0 || main_lt !== 3'b001 || side_lt !== 3'b100)
            $display("FAIL fault_reset: got state=%0d fault=%b main=%b side=%b expected 0 0 001 100",
                     state, fault, main_lt, side_lt);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        flags    = 4'b0000;
        car_side = 1'b0;
        test_reset();
        test_no_car();
        test_full_cycle();
        test_blanking();
        test_wrong_flag();
        test_simultaneous();
        test_watchdog();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
